// File: rtl/pixel_frame_swap_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pixel_frame_swap_ctrl_pkg
// Shared definitions for the LED panel double-buffer controller:
//   - swap_state_e : controller state encoding (FILL / PENDING / SWAP)
//   - BANK0/BANK1  : pixel bank indices used for o_front and enable vectors
//   - STAT_W       : width of the optional statistics counters
// -----------------------------------------------------------------------------
package pixel_frame_swap_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_FILL    = 2'd0,   // loader may write the back bank
      ST_PENDING = 2'd1,   // back bank complete, waiting for a scan frame boundary
      ST_SWAP    = 2'd2    // single cycle, front/back exchange at its end
   } swap_state_e;

   localparam logic BANK0 = 1'b0;
   localparam logic BANK1 = 1'b1;

   localparam int STAT_W = 16;

endpackage

// File: rtl/pixel_frame_swap_ctrl.sv
// -----------------------------------------------------------------------------
// pixel_frame_swap_ctrl
// Double-buffer controller for the LED panel pixel store. The GIF frame
// decoder (loader) writes the back bank while panel scan-out reads the front
// bank. Front and back are exchanged only at a scan frame boundary after the
// loader has committed a complete frame, so the panel never shows a torn frame.
// The two pixel banks sit outside this block and are driven via o_ram_*.
//
// Ports:
//   i_clk, i_rst_n        clock (rising edge), async active-low reset
//   i_ld_valid/addr/data  loader write request
//   i_ld_commit           pulse: back bank holds a complete frame
//   o_ld_ready            loader writes accepted this cycle
//   i_sc_req/addr         scan-out read request
//   i_sc_frame_end        pulse: scanner finished the last pixel of a frame
//   o_sc_data/o_sc_valid  read result, one cycle after i_sc_req
//   o_front               current front bank index
//   o_ram_w_*             shared write address/data, per-bank write enable
//   o_ram_r_*             shared read address, per-bank read enable
//   i_ram_r_data0/1       read data from bank 0 / bank 1
//   o_dbg_state           controller state (swap_state_e encoding)
//   o_swap_count          (PIXEL_SWAP_STATS_EN) swaps performed, wraps
//   o_stall_cycles        (PIXEL_SWAP_STATS_EN) cycles loader was held off,
//                         saturates
//
// Build option: define PIXEL_SWAP_STATS_EN to add the statistics counters.
//
// Handshake: a loader write transfers in every cycle where
// i_ld_valid && o_ld_ready; o_ld_ready does not depend on i_ld_valid, and an
// unaccepted request is simply not written (the loader keeps it asserted).
// -----------------------------------------------------------------------------
module pixel_frame_swap_ctrl
   import pixel_frame_swap_ctrl_pkg::*;
#(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 16
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_ld_valid,
   input  logic [ADDR_W-1:0] i_ld_addr,
   input  logic [DATA_W-1:0] i_ld_data,
   input  logic              i_ld_commit,
   output logic              o_ld_ready,
   input  logic              i_sc_req,
   input  logic [ADDR_W-1:0] i_sc_addr,
   input  logic              i_sc_frame_end,
   output logic [DATA_W-1:0] o_sc_data,
   output logic              o_sc_valid,
   output logic              o_front,
   output logic [ADDR_W-1:0] o_ram_w_addr,
   output logic [DATA_W-1:0] o_ram_w_data,
   output logic [1:0]        o_ram_w_en,
   output logic [ADDR_W-1:0] o_ram_r_addr,
   output logic [1:0]        o_ram_r_en,
   input  logic [DATA_W-1:0] i_ram_r_data0,
   input  logic [DATA_W-1:0] i_ram_r_data1,
   output logic [1:0]        o_dbg_state
`ifdef PIXEL_SWAP_STATS_EN
   ,
   output logic [STAT_W-1:0] o_swap_count,
   output logic [STAT_W-1:0] o_stall_cycles
`endif
);

   swap_state_e       state_q;
   swap_state_e       state_d;
   logic              awake_q;     // low only until the first edge after reset
   logic              front_q;
   logic              rd_valid_q;
   logic              rd_bank_q;   // bank that served the outstanding read
   logic [DATA_W-1:0] sc_hold_q;   // last returned pixel, held while idle
   logic [DATA_W-1:0] rd_data_sel;
   logic              ld_ready;
   logic              wr_accept;

   // ---------------------------------------------------------------------
   // State register and datapath registers
   // ---------------------------------------------------------------------
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q    <= ST_FILL;
         awake_q    <= 1'b0;
         front_q    <= BANK0;
         rd_valid_q <= 1'b0;
         rd_bank_q  <= BANK0;
         sc_hold_q  <= '0;
      end else begin
         state_q    <= state_d;
         awake_q    <= 1'b1;
         // The exchange lands at the end of the SWAP cycle, so a read issued
         // during SWAP still captures the old front index below.
         if (state_q == ST_SWAP) begin
            front_q <= ~front_q;
         end
         rd_valid_q <= i_sc_req;
         if (i_sc_req) begin
            rd_bank_q <= front_q;
         end
         if (rd_valid_q) begin
            sc_hold_q <= rd_data_sel;
         end
      end
   end

   // ---------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_FILL: begin
            // A frame_end without a prior commit is ignored: the scanner
            // just repeats the current front frame.
            if (i_ld_commit) begin
               state_d = i_sc_frame_end ? ST_SWAP : ST_PENDING;
            end
         end
         ST_PENDING: begin
            if (i_sc_frame_end) begin
               state_d = ST_SWAP;
            end
         end
         ST_SWAP: begin
            state_d = ST_FILL;
         end
         default: begin
            state_d = ST_FILL;
         end
      endcase
   end

   // ---------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------
   assign rd_data_sel = rd_bank_q ? i_ram_r_data1 : i_ram_r_data0;

   always_comb begin
      ld_ready   = awake_q && (state_q == ST_FILL);
      wr_accept  = i_ld_valid && ld_ready;
      o_ld_ready = ld_ready;

      // Writes only ever go to the back bank.
      o_ram_w_addr          = i_ld_addr;
      o_ram_w_data          = i_ld_data;
      o_ram_w_en            = 2'b00;
      o_ram_w_en[~front_q]  = wr_accept;

      o_ram_r_addr          = i_sc_addr;
      o_ram_r_en            = 2'b00;
      o_ram_r_en[front_q]   = i_sc_req;

      o_sc_valid  = rd_valid_q;
      o_sc_data   = rd_valid_q ? rd_data_sel : sc_hold_q;
      o_front     = front_q;
      o_dbg_state = state_q;
   end

`ifdef PIXEL_SWAP_STATS_EN
   logic [STAT_W-1:0] swap_cnt_q;
   logic [STAT_W-1:0] stall_cnt_q;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         swap_cnt_q  <= '0;
         stall_cnt_q <= '0;
      end else begin
         if (state_q == ST_SWAP) begin
            swap_cnt_q <= swap_cnt_q + 1'b1;
         end
         if (i_ld_valid && !ld_ready && (stall_cnt_q != {STAT_W{1'b1}})) begin
            stall_cnt_q <= stall_cnt_q + 1'b1;
         end
      end
   end

   assign o_swap_count   = swap_cnt_q;
   assign o_stall_cycles = stall_cnt_q;
`else
   // Statistics counters are not built in this configuration.
`endif

endmodule

// File: doc/pixel_frame_swap_ctrl.md
Name: pixel_frame_swap_ctrl

Overview:
- Double-buffer controller for the LED panel pixel store; owns two pixel_ram_block instances (bank 0, bank 1) via their write/read ports.
- Loader (GIF frame decoder) writes the back bank; panel scan-out reads the front bank.
- Front/back are swapped only at a scan frame boundary after the loader commits a complete frame, so no frame tears.

Parameters:
ADDR_W, 8, pixel address width (256 pixels per bank)
DATA_W, 16, pixel word width

Ports:
i_clk  in  1  system clock; all logic rising-edge
i_rst_n  in  1  reset, asynchronous assert, active-low
i_ld_valid  in  1  loader write request
i_ld_addr  in  ADDR_W  loader pixel address
i_ld_data  in  DATA_W  loader pixel data
i_ld_commit  in  1  pulse: back bank holds a complete frame
o_ld_ready  out  1  loader writes accepted this cycle
i_sc_req  in  1  scan-out read request
i_sc_addr  in  ADDR_W  scan-out pixel address
i_sc_frame_end  in  1  pulse: scanner finished the last pixel of a frame
o_sc_data  out  DATA_W  read data
o_sc_valid  out  1  o_sc_data valid
o_front  out  1  current front bank index
o_ram_w_addr  out  ADDR_W  shared write address to both banks
o_ram_w_data  out  DATA_W  shared write data
o_ram_w_en  out  2  per-bank write enable
o_ram_r_addr  out  ADDR_W  shared read address
o_ram_r_en  out  2  per-bank read enable
i_ram_r_data0  in  DATA_W  bank 0 read data
i_ram_r_data1  in  DATA_W  bank 1 read data

Behaviour:
- Reset values: state FILL, o_front=0, o_ld_ready=0, o_sc_valid=0, o_sc_data=0, all enables 0. o_ld_ready rises the first cycle after reset release.
- States:
  - FILL: o_ld_ready=1.
  - PENDING: o_ld_ready=0; waits for i_sc_frame_end.
  - SWAP: one cycle; o_ld_ready=0; o_front toggles at the end of the cycle; returns to FILL.
- Write path: combinational pass-through.
  - o_ram_w_en[~o_front] = i_ld_valid & o_ld_ready; the other bit is 0.
  - A write is accepted when i_ld_valid & o_ld_ready.
  - Writes never target the front bank.
- Commit handling:
  - i_ld_commit in FILL: go to PENDING.
  - If i_sc_frame_end is also high in that cycle, go directly to SWAP.
  - A write accepted in the same cycle as the commit belongs to the committed frame.
  - i_ld_commit outside FILL is ignored.
- i_sc_frame_end in FILL or SWAP: ignored, no swap. The same frame is rescanned.
- Read path: o_ram_r_addr=i_sc_addr; o_ram_r_en[o_front]=i_sc_req.
  - The bank index is registered with the request.
  - The next cycle, o_sc_valid=1 and o_sc_data = the registered bank's data, selected combinationally.
  - Latency is 1 cycle; back-to-back requests give a result every cycle.
  - A read issued during the SWAP cycle returns old-front data, even though o_front has toggled.
  - o_sc_data holds its last value when o_sc_valid=0.
- Reset asserted mid-operation returns all state to reset values immediately. RAM contents are undefined thereafter.

Optional Feature:
PIXEL_SWAP_STATS_EN
- Defined: adds output o_swap_count (16-bit) and output o_stall_cycles (16-bit).
  - o_swap_count increments on each SWAP and wraps.
  - o_stall_cycles counts cycles with i_ld_valid=1 & o_ld_ready=0 and saturates at 0xFFFF.
  - Both reset to 0.
- Undefined: neither port nor counter exists. Core behaviour is identical.

Decomposition:
- Shared package: state encoding constants (FILL=2'd0, PENDING=2'd1, SWAP=2'd2) and bank index constants.
- No new sub-module: the FSM and datapath stay in one module.
- The top level instantiates two existing pixel_ram_block banks and wires them to the o_ram_* ports.

Test Plan:
- Reset release, then write addr 0x05=0xBEEF, commit, pulse frame_end -> o_front goes 0->1 after the SWAP cycle; scan read addr 0x05 returns 0xBEEF with o_sc_valid one cycle later.
- Commit without frame_end for 100 cycles -> o_ld_ready=0 throughout, no o_ram_w_en, o_front unchanged; frame_end -> swap.
- frame_end in FILL with no commit -> o_front unchanged; reads return the previous front contents.
- Commit and frame_end in the same cycle, with a write to 0xFF=0x1234 also that cycle -> SWAP next cycle; after the swap, read 0xFF returns 0x1234.
- Read request in the SWAP cycle (front bank 0 holds 0x1111, back bank 1 holds 0x2222 at addr 0x10) -> returns 0x1111.
- With PIXEL_SWAP_STATS_EN: 3 swaps and 7 stalled valid cycles -> o_swap_count=3, o_stall_cycles=7; async reset mid-PENDING -> both counters 0, state FILL, o_front=0.
